// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: scalar aliases, reset defaults,
// the F/D payload struct and the fetch FSM state encoding.
package fetch_stage_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PC_RESET_DEF  = 64'h8000_0000;
  localparam u32 NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    SQUASH,
    MISALIGN
  } fetch_state_t;

  typedef struct packed {
    logic valid;
    logic misalign;
    u64   pc;
    u32   raw_instr;
  } fetch_data_t;

  // Instructions are 4-byte aligned; any low bit set means no bus access.
  function automatic logic is_misaligned(input u64 pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC and pending-redirect-target selection for the fetch FSM.
module fetch_pc_next
  import fetch_stage_pkg::*;
(
  input  u64           pc_q,
  input  u64           pending_q,
  input  fetch_state_t state_q,
  input  logic         redirect_valid,
  input  u64           redirect_pc,
  input  logic         data_ok,
  output u64           pc_d,
  output u64           pending_d
);

  // Redirects land in pc directly unless a bus request is still owed a
  // response, in which case the target parks in pending until it returns.
  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE, HOLD, MISALIGN: begin
        if (redirect_valid) pc_d = redirect_pc;
      end
      REQ: begin
        if (is_misaligned(pc_q)) begin
          if (redirect_valid) pc_d = redirect_pc;
        end else if (redirect_valid) begin
          if (data_ok) pc_d = redirect_pc;
          else         pending_d = redirect_pc;
        end else if (data_ok) begin
          pc_d = pc_q + 64'd4;
        end
      end
      SQUASH: begin
        if (redirect_valid) begin
          if (data_ok) pc_d = redirect_pc;
          else         pending_d = redirect_pc;
        end else if (data_ok) begin
          pc_d = pending_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one bus request at a
// time and registers the returned instruction for the F/D boundary.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter u64 PC_RESET  = PC_RESET_DEF,
  parameter u32 NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output fetch_data_t dataF
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           pending_q, pending_d;
  fetch_data_t  data_q, data_d;

  fetch_pc_next u_pc_next (
    .pc_q          (pc_q),
    .pending_q     (pending_q),
    .state_q       (state_q),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .data_ok       (iresp_data_ok),
    .pc_d          (pc_d),
    .pending_d     (pending_d)
  );

  // Bus request is driven straight from state so reset drops it at once;
  // SQUASH keeps the old address on the bus until its response drains.
  assign ireq_valid = ((state_q == REQ) && !is_misaligned(pc_q)) || (state_q == SQUASH);
  assign ireq_addr  = pc_q;
  assign dataF      = data_q;

  // Next-state and F/D payload; redirect outranks stall everywhere.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) data_d.valid = 1'b0;
      end
      REQ: begin
        if (redirect_valid) begin
          data_d.valid = 1'b0;
          state_d = (!is_misaligned(pc_q) && !iresp_data_ok) ? SQUASH : REQ;
        end else if (is_misaligned(pc_q)) begin
          data_d.valid     = 1'b1;
          data_d.misalign  = 1'b1;
          data_d.pc        = pc_q;
          data_d.raw_instr = NOP_INSTR;
          state_d          = MISALIGN;
        end else if (iresp_data_ok) begin
          data_d.valid     = 1'b1;
          data_d.misalign  = 1'b0;
          data_d.pc        = pc_q;
          data_d.raw_instr = iresp_data;
          state_d          = stall ? HOLD : REQ;
        end else begin
          data_d.valid = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid || !stall) begin
          data_d.valid = 1'b0;
          state_d      = REQ;
        end
      end
      SQUASH: begin
        data_d.valid = 1'b0;
        if (iresp_data_ok) state_d = REQ;
      end
      MISALIGN: begin
        if (redirect_valid) begin
          data_d.valid = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= PC_RESET;
      pending_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table from reset
// release, then a hand-written asynchronous-reset sequence.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, iresp_data_ok;
  logic [63:0] redirect_pc, ireq_addr;
  logic [31:0] iresp_data;
  logic        ireq_valid;
  fetch_data_t dataF;

  int n_chk = 0;
  int n_pass = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dataF         (dataF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [63:0] rpc;
    logic        dok;
    logic [31:0] data;
    logic        e_req;
    logic [63:0] e_addr;
    fetch_data_t e_df;
  } vec_t;

  vec_t vq[$];

  function automatic fetch_data_t df(input logic v, input logic m,
                                     input logic [63:0] pc, input logic [31:0] ins);
    fetch_data_t d;
    d.valid = v; d.misalign = m; d.pc = pc; d.raw_instr = ins;
    return d;
  endfunction

  task automatic add(input logic st, input logic rv, input logic [63:0] rpc,
                     input logic dok, input logic [31:0] dat,
                     input logic er, input logic [63:0] ea, input fetch_data_t ed);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc; v.dok = dok; v.data = dat;
    v.e_req = er; v.e_addr = ea; v.e_df = ed;
    vq.push_back(v);
  endtask

  task automatic chk_req(input string nm, input logic er, input logic [63:0] ea);
    n_chk++;
    if (ireq_valid === er && (!er || ireq_addr === ea)) n_pass++;
    else $display("FAIL %s: ireq got v=%b a=%h want v=%b a=%h", nm, ireq_valid, ireq_addr, er, ea);
  endtask

  task automatic chk_df(input string nm, input fetch_data_t ed);
    n_chk++;
    if (ed.valid ? (dataF === ed) : (dataF.valid === 1'b0)) n_pass++;
    else $display("FAIL %s: dataF got %h want %h", nm, dataF, ed);
  endtask

  localparam logic [63:0] B = 64'h8000_0000;
  localparam logic [63:0] X = 64'h0;
  localparam logic [31:0] Z = 32'h0;

  initial begin
    fetch_data_t zero;
    fetch_data_t hold_df;
    zero = '0;
    stall = 0; redirect_valid = 0; redirect_pc = '0; iresp_data_ok = 0; iresp_data = '0;
    rst_n = 1'b0;
    #12;
    chk_req("reset_ireq", 1'b0, X);
    n_chk++;
    if (dataF === zero) n_pass++;
    else $display("FAIL reset_dataF: got %h want 0", dataF);

    hold_df = df(1, 0, B + 64'hC, 32'h0030_0213);
    //   st rv rpc              dok data          req addr       expected dataF
    add(0, 0, X,               0, Z,            0, X,          df(0,0,X,Z));                       // IDLE
    add(0, 0, X,               1, 32'h0000_0093, 1, B,          df(1,0,B,32'h0000_0093));
    add(0, 0, X,               1, 32'h0010_0113, 1, B+4,        df(1,0,B+4,32'h0010_0113));
    add(0, 0, X,               0, Z,            1, B+8,        df(0,0,X,Z));                       // delayed rsp
    add(0, 0, X,               0, Z,            1, B+8,        df(0,0,X,Z));
    add(0, 0, X,               0, Z,            1, B+8,        df(0,0,X,Z));
    add(0, 0, X,               1, 32'h0020_0193, 1, B+8,        df(1,0,B+8,32'h0020_0193));
    add(1, 0, X,               1, 32'h0030_0213, 1, B+12,       hold_df);                           // capture, stall
    add(1, 0, X,               0, Z,            0, X,          hold_df);                           // HOLD
    add(0, 0, X,               0, Z,            0, X,          df(0,0,X,Z));                       // stall drops
    add(0, 0, X,               1, 32'h0040_0293, 1, B+16,       df(1,0,B+16,32'h0040_0293));
    add(0, 1, B+64'h1000,      0, Z,            1, B+20,       df(0,0,X,Z));                       // -> SQUASH
    add(0, 0, X,               0, Z,            1, B+20,       df(0,0,X,Z));
    add(0, 0, X,               1, 32'hDEAD_BEEF, 1, B+20,       df(0,0,X,Z));                       // dropped
    add(0, 0, X,               1, 32'h0050_0313, 1, B+64'h1000, df(1,0,B+64'h1000,32'h0050_0313));
    add(0, 1, B+64'h2000,      1, 32'hBAD0_0001, 1, B+64'h1004, df(0,0,X,Z));                       // redirect+ok
    add(0, 1, B+64'h3000,      0, Z,            1, B+64'h2000, df(0,0,X,Z));                       // -> SQUASH
    add(0, 1, B+64'h4000,      0, Z,            1, B+64'h2000, df(0,0,X,Z));                       // overwrite
    add(0, 0, X,               1, 32'hBAD0_0002, 1, B+64'h2000, df(0,0,X,Z));
    add(0, 0, X,               1, 32'h0060_0393, 1, B+64'h4000, df(1,0,B+64'h4000,32'h0060_0393));
    add(1, 0, X,               1, 32'h0070_0413, 1, B+64'h4004, df(1,0,B+64'h4004,32'h0070_0413));
    add(1, 1, B+2,             0, Z,            0, X,          df(0,0,X,Z));                       // redirect beats stall
    add(0, 0, X,               0, Z,            0, X,          df(1,1,B+2,32'h0000_0013));         // misaligned
    add(0, 0, X,               0, Z,            0, X,          df(1,1,B+2,32'h0000_0013));
    add(1, 0, X,               0, Z,            0, X,          df(1,1,B+2,32'h0000_0013));
    add(0, 1, B,               0, Z,            0, X,          df(0,0,X,Z));                       // recover
    add(0, 0, X,               1, 32'h0000_0093, 1, B,          df(1,0,B,32'h0000_0093));
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hBAD0_0003, 1, B+4, df(0,0,X,Z));
    add(0, 0, X,               1, 32'h0080_0493, 1, 64'hFFFF_FFFF_FFFF_FFFC,
        df(1,0,64'hFFFF_FFFF_FFFF_FFFC,32'h0080_0493));
    add(0, 0, X,               1, 32'h0090_0513, 1, 64'h0,      df(1,0,64'h0,32'h0090_0513));       // wrapped

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      stall = vq[i].stall; redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
      iresp_data_ok = vq[i].dok; iresp_data = vq[i].data;
      #1 chk_req($sformatf("vec%0d_req", i), vq[i].e_req, vq[i].e_addr);
      @(posedge clk);
      #1 chk_df($sformatf("vec%0d_df", i), vq[i].e_df);
      @(negedge clk);
    end

    // Asynchronous reset with a request outstanding and valid data on dataF.
    stall = 0; redirect_valid = 0; iresp_data_ok = 0;
    #1 chk_req("pre_rst_req", 1'b1, 64'h4);
    #1 rst_n = 1'b0;
    #1 chk_req("async_rst_req", 1'b0, X);
    n_chk++;
    if (dataF === zero) n_pass++;
    else $display("FAIL async_rst_dataF: got %h want 0", dataF);
    iresp_data_ok = 1; iresp_data = 32'hBAD0_0004;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_df("late_ok_ignored", df(0,0,X,Z));
    @(negedge clk);
    iresp_data = 32'h0000_0093;
    #1 chk_req("post_rst_req", 1'b1, B);
    @(posedge clk);
    #1 chk_df("post_rst_capture", df(1,0,B,32'h0000_0093));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
